// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the counter library
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Bits needed to hold m distinct values (0..m-1); used to validate MODULUS against WIDTH.
    function automatic int clog2_mod(input int m);
        int r;
        longint v;
        r = 0;
        v = 1;
        while (v < longint'(m)) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_step_alu.sv
// rtl/mod_step_alu.sv - next-count arithmetic for the modulo up/down counter
module mod_step_alu
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 4,
    parameter int        MODULUS = 6,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             updown,
    output logic [WIDTH-1:0] next_count,
    output logic             bound_hit
);

    // One extra bit so MODULUS = 2**WIDTH and count+s never overflow.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   cnt_w;
    logic [WIDTH:0]   s_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sum_n;
    logic [WIDTH-1:0] diff_n;
    logic [WIDTH-1:0] wrap_up_n;
    logic [WIDTH-1:0] wrap_dn_n;

    assign cnt_w     = {1'b0, count};
    assign s_w       = {1'b0, s};
    assign sum_w     = cnt_w + s_w;
    assign sum_n     = WIDTH'(sum_w);
    assign diff_n    = WIDTH'(cnt_w - s_w);
    assign wrap_up_n = WIDTH'(sum_w - MOD_W);
    assign wrap_dn_n = WIDTH'(cnt_w + MOD_W - s_w);

    always_comb begin
        next_count = count;
        bound_hit  = 1'b0;
        if (updown) begin
            if (sum_w <= MAX_W) begin
                next_count = sum_n;
            end else begin
                bound_hit  = 1'b1;
                next_count = (MODE == CNT_WRAP) ? wrap_up_n : MAX_N;
            end
        end else begin
            if (cnt_w >= s_w) begin
                next_count = diff_n;
            end else begin
                bound_hit  = 1'b1;
                next_count = (MODE == CNT_WRAP) ? wrap_dn_n : '0;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - parametrised modulo up/down counter with load, enable and terminal-count flag
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 4,
    parameter int        MODULUS = 6,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             updown,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || clog2_mod(MODULUS) > WIDTH) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS %0d outside 2..2**%0d", MODULUS, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] alu_next;
    logic             alu_bound;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;

    // Oversized steps and load values are clamped so count stays inside 0..MODULUS-1.
    assign s_eff        = ({1'b0, step} >= MOD_W) ? MAX_N : step;
    assign load_clamped = ({1'b0, load_val} > MAX_W) ? MAX_N : load_val;

    mod_step_alu #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .MODE    (MODE)
    ) u_alu (
        .count      (count),
        .s          (s_eff),
        .updown     (updown),
        .next_count (alu_next),
        .bound_hit  (alu_bound)
    );

    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = alu_next;
            tc_d    = alu_bound;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
        end
    end

    assign at_max = (count == MAX_N);
    assign at_min = (count == '0);

    always_ff @(posedge clk) begin
        if (rst_n && en && !load) begin
            assert ({1'b0, step} < MOD_W)
            else $warning("mod_updown_counter: step %0d above MODULUS-1, clamped to %0d", step, MAX_N);
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - randomized self-checking bench for mod_updown_counter
module tb_mod_updown_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       en = 1'b0, load = 1'b0, updown = 1'b1;
    logic [3:0] load_val = '0, step = '0;
    logic [3:0] w_count, s_count;
    logic       w_tc, w_at_max, w_at_min;
    logic       s_tc, s_at_max, s_at_min;

    logic       f_en = 1'b0, f_load = 1'b0, f_updown = 1'b1;
    logic [7:0] f_load_val = '0, f_step = '0;
    logic [7:0] f_count;
    logic       f_tc, f_at_max, f_at_min;

    mod_updown_counter #(.WIDTH(4), .MODULUS(6), .MODE(CNT_WRAP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .updown(updown), .step(step), .count(w_count), .tc(w_tc),
        .at_max(w_at_max), .at_min(w_at_min)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(6), .MODE(CNT_SAT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .updown(updown), .step(step), .count(s_count), .tc(s_tc),
        .at_max(s_at_max), .at_min(s_at_min)
    );

    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .MODE(CNT_WRAP)) dut_full (
        .clk(clk), .rst_n(rst_n), .en(f_en), .load(f_load), .load_val(f_load_val),
        .updown(f_updown), .step(f_step), .count(f_count), .tc(f_tc),
        .at_max(f_at_max), .at_min(f_at_min)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the counter value.
    int m_w = 0, m_s = 0, m_f = 0;
    bit t_w = 0, t_s = 0, t_f = 0;

    task automatic model_update(input int modulus, input bit sat, input bit ld, input int lv,
                                input bit e, input bit ud, input int st,
                                inout int c, inout bit t);
        int s;
        int n;
        if (ld) begin
            c = (lv > modulus - 1) ? modulus - 1 : lv;
            t = 0;
        end else if (e) begin
            s = (st >= modulus) ? modulus - 1 : st;
            n = ud ? c + s : c - s;
            if (n >= modulus) begin
                t = 1;
                c = sat ? modulus - 1 : n % modulus;
            end else if (n < 0) begin
                t = 1;
                c = sat ? 0 : n + modulus;
            end else begin
                t = 0;
                c = n;
            end
        end else begin
            t = 0;
        end
    endtask

    task automatic check_all();
        check_eq("wrap_count", w_count, m_w);
        check_eq("wrap_tc", w_tc, t_w);
        check_eq("wrap_at_max", w_at_max, m_w == 5);
        check_eq("wrap_at_min", w_at_min, m_w == 0);
        check_eq("sat_count", s_count, m_s);
        check_eq("sat_tc", s_tc, t_s);
        check_eq("sat_at_max", s_at_max, m_s == 5);
        check_eq("sat_at_min", s_at_min, m_s == 0);
        check_eq("full_count", f_count, m_f);
        check_eq("full_tc", f_tc, t_f);
        check_eq("full_at_max", f_at_max, m_f == 255);
        check_eq("full_at_min", f_at_min, m_f == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(6, 0, load, load_val, en, updown, step, m_w, t_w);
        model_update(6, 1, load, load_val, en, updown, step, m_s, t_s);
        model_update(256, 0, f_load, f_load_val, f_en, f_updown, f_step, m_f, t_f);
        #1;
        check_all();
    endtask

    // Asserts rst_n between edges, checks the immediate clear, releases on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_w = 0; m_s = 0; m_f = 0;
        t_w = 0; t_s = 0; t_f = 0;
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input bit ld, input int lv, input bit e, input bit ud, input int st);
        load     = ld;
        load_val = 4'(lv);
        en       = e;
        updown   = ud;
        step     = 4'(st);
    endtask

    int t1_exp[7] = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        // 1: reset with en high, then count up through the wrap
        set_in(0, 0, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("t1_seq", w_count, t1_exp[i]);
            check_eq("t1_tc", w_tc, i == 5);
        end

        // 2: down wrap, larger step, oversized step
        set_in(1, 0, 0, 0, 1); tick();
        set_in(0, 0, 1, 0, 1); tick();
        check_eq("t2_down_wrap", w_count, 5);
        check_eq("t2_down_wrap_tc", w_tc, 1);
        set_in(1, 2, 0, 0, 4); tick();
        set_in(0, 0, 1, 0, 4); tick();
        check_eq("t2_step4", w_count, 4);
        check_eq("t2_step4_tc", w_tc, 1);
        set_in(0, 0, 1, 0, 9); tick();
        check_eq("t2_step9", w_count, 5);

        // 3: saturation
        set_in(1, 4, 0, 1, 2); tick();
        set_in(0, 0, 1, 1, 2); tick();
        check_eq("t3_sat_up", s_count, 5);
        check_eq("t3_sat_up_tc", s_tc, 1);
        tick();
        check_eq("t3_sat_hold_tc", s_tc, 1);
        set_in(1, 1, 0, 0, 3); tick();
        set_in(0, 0, 1, 0, 3); tick();
        check_eq("t3_sat_dn", s_count, 0);
        check_eq("t3_sat_dn_tc", s_tc, 1);
        set_in(0, 0, 0, 0, 3); tick();
        check_eq("t3_sat_idle_tc", s_tc, 0);

        // 4: load priority and clamp
        set_in(1, 3, 1, 1, 1); tick();
        check_eq("t4_load3", w_count, 3);
        set_in(1, 9, 1, 1, 1); tick();
        check_eq("t4_load9", w_count, 5);
        set_in(1, 2, 1, 1, 1); tick();
        check_eq("t4_load_on_wrap", w_count, 2);
        check_eq("t4_load_on_wrap_tc", w_tc, 0);

        // 5: hold via step=0 and en=0, then async reset at count 4
        set_in(0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 1, 3); tick();
        set_in(1, 4, 0, 1, 1); tick();
        set_in(0, 0, 1, 1, 1);
        do_reset();
        check_eq("t5_async_clear", w_count, 0);

        // 6: full-range 8-bit counter
        set_in(0, 0, 0, 1, 0);
        f_load = 1; f_load_val = 8'd255; tick();
        f_load = 0; f_en = 1; f_updown = 1; f_step = 8'd1; tick();
        check_eq("t6_up_wrap", f_count, 0);
        check_eq("t6_up_wrap_tc", f_tc, 1);
        f_updown = 0; tick();
        check_eq("t6_dn_wrap", f_count, 255);
        check_eq("t6_dn_wrap_tc", f_tc, 1);

        // Randomized traffic on all three counters
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 1),
                   ($urandom_range(0, 49) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5));
            f_load     = ($urandom_range(0, 9) == 0);
            f_load_val = 8'($urandom);
            f_en       = ($urandom_range(0, 4) != 0);
            f_updown   = 1'($urandom);
            f_step     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
